// File: rtl/eve_add_gene_sequencer_pkg.sv
// Shared definitions for the EvE add-gene sequencer: gene layout, idle gene, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package eve_add_gene_sequencer_pkg;

   localparam int GENE_W   = 64;
   localparam int ID_HI    = 63;
   localparam int ID_LO    = 56;
   localparam int TYPE_BIT = 55;   // 1 = connection gene, 0 = node gene

   localparam logic [7:0]        ID_INVALID   = 8'hFF;
   localparam logic [GENE_W-1:0] GENE_INVALID = {GENE_W{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT,
      ST_FEED,
      ST_CAPTURE,
      ST_DRAIN,
      ST_DONE
   } seq_state_t;

   // A gene slot carries data unless its id field holds the invalid/terminator id.
   function automatic logic gene_is_valid(input logic [GENE_W-1:0] gene);
      return gene[ID_HI:ID_LO] != ID_INVALID;
   endfunction

endpackage

// File: rtl/eve_add_gene_sequencer_if.sv
// Bundles the parent-RAM read port, engine gene ports and child-RAM write port.
// Latency: n/a (wires only); parent read data returns one cycle after the strobe.
// Backpressure: none; the RAMs and engine always accept.
interface eve_add_gene_sequencer_if #(
   parameter int ADDR_W = 10
);
   import eve_add_gene_sequencer_pkg::*;

   logic              par_rd_en;
   logic [ADDR_W-1:0] par_rd_addr;
   logic [GENE_W-1:0] par_rd_data;

   logic [GENE_W-1:0] eng_in_gene;
   logic [GENE_W-1:0] eng_out1;
   logic [GENE_W-1:0] eng_out2;
   logic [GENE_W-1:0] eng_out3;

   logic              child_wr_en;
   logic [ADDR_W-1:0] child_wr_addr;
   logic [GENE_W-1:0] child_wr_data;

   // Sequencer side
   modport master (
      output par_rd_en, par_rd_addr,
      input  par_rd_data,
      output eng_in_gene,
      input  eng_out1, eng_out2, eng_out3,
      output child_wr_en, child_wr_addr, child_wr_data
   );

   // Memories and engine side
   modport slave (
      input  par_rd_en, par_rd_addr,
      output par_rd_data,
      input  eng_in_gene,
      output eng_out1, eng_out2, eng_out3,
      input  child_wr_en, child_wr_addr, child_wr_data
   );

endinterface

// File: rtl/eve_add_gene_sequencer_slot.sv
// Picks the lowest-index pending output slot and returns the mask with that slot cleared.
// Latency: combinational.
// Backpressure: none; the caller decides whether to consume the selected slot.
module eve_slot_compactor (
   input  logic [2:0] valid,
   output logic       any,
   output logic [1:0] sel,
   output logic [2:0] valid_next
);

   // Fixed priority slot 0 > 1 > 2 keeps the engine's output order in the child genome.
   always_comb begin
      any        = |valid;
      sel        = 2'd0;
      valid_next = valid;
      if (valid[0]) begin
         sel           = 2'd0;
         valid_next[0] = 1'b0;
      end else if (valid[1]) begin
         sel           = 2'd1;
         valid_next[1] = 1'b0;
      end else if (valid[2]) begin
         sel           = 2'd2;
         valid_next[2] = 1'b0;
      end
   end

endmodule

// File: rtl/eve_add_gene_sequencer.sv
// Walks one parent genome through the add-gene engine and compacts valid outputs into the child RAM.
// Latency: 4 cycles per parent gene plus 1 per valid engine output; done pulses after the last gene.
// Backpressure: none; stops early on a terminator gene or when the child RAM is full (overflow).
module eve_add_gene_sequencer
   import eve_add_gene_sequencer_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic                         clk,
   input  logic                         Reset,
   input  logic                         start,
   input  logic [ADDR_W:0]              parent_len,
   eve_add_gene_sequencer_if.master     bus,
   output logic                         busy,
   output logic                         done,
   output logic                         overflow,
   output logic [ADDR_W:0]              child_len
);

   seq_state_t        state, state_n;
   logic [ADDR_W:0]   rd_ptr;
   logic [ADDR_W:0]   len_q;
   logic [GENE_W-1:0] eng_in_q;
   logic [GENE_W-1:0] slot0, slot1, slot2;
   logic [2:0]        valid;
   logic [2:0]        cap_valid;
   logic              any_valid;
   logic [1:0]        sel;
   logic [2:0]        valid_next;
   logic              more;
   logic              rd_en;
   logic              wr_en;
   logic              child_full;

   eve_slot_compactor u_compactor (
      .valid      (valid),
      .any        (any_valid),
      .sel        (sel),
      .valid_next (valid_next)
   );

   assign cap_valid  = {gene_is_valid(bus.eng_out3), gene_is_valid(bus.eng_out2),
                        gene_is_valid(bus.eng_out1)};
   assign more       = rd_ptr < len_q;
   // Counter width is ADDR_W+1, so the top bit alone marks a full child RAM.
   assign child_full = child_len[ADDR_W];

   // Next-state and strobes; a zero-valid capture skips DRAIN so it costs no cycles.
   always_comb begin
      state_n = state;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) state_n = (parent_len == '0) ? ST_DONE : ST_READ;
         end
         ST_READ: begin
            rd_en   = 1'b1;
            state_n = ST_WAIT;
         end
         ST_WAIT: begin
            state_n = gene_is_valid(bus.par_rd_data) ? ST_FEED : ST_DONE;
         end
         ST_FEED: begin
            state_n = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (|cap_valid) state_n = ST_DRAIN;
            else            state_n = more ? ST_READ : ST_DONE;
         end
         ST_DRAIN: begin
            if (!any_valid) begin
               state_n = more ? ST_READ : ST_DONE;
            end else if (child_full) begin
               state_n = ST_DONE;
            end else begin
               wr_en = 1'b1;
               if (valid_next == 3'b000) state_n = more ? ST_READ : ST_DONE;
            end
         end
         ST_DONE: begin
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // State register plus the datapath registers each state owns.
   always_ff @(posedge clk) begin
      if (Reset) begin
         state     <= ST_IDLE;
         rd_ptr    <= '0;
         len_q     <= '0;
         child_len <= '0;
         overflow  <= 1'b0;
         eng_in_q  <= GENE_INVALID;
         slot0     <= GENE_INVALID;
         slot1     <= GENE_INVALID;
         slot2     <= GENE_INVALID;
         valid     <= 3'b000;
      end else begin
         state <= state_n;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  len_q     <= parent_len;
                  rd_ptr    <= '0;
                  child_len <= '0;
                  overflow  <= 1'b0;
               end
            end
            ST_READ: rd_ptr <= rd_ptr + 1'b1;
            ST_WAIT: begin
               if (gene_is_valid(bus.par_rd_data)) eng_in_q <= bus.par_rd_data;
            end
            ST_CAPTURE: begin
               eng_in_q <= GENE_INVALID;
               slot0    <= bus.eng_out1;
               slot1    <= bus.eng_out2;
               slot2    <= bus.eng_out3;
               valid    <= cap_valid;
            end
            ST_DRAIN: begin
               if (any_valid && child_full) begin
                  overflow <= 1'b1;
                  valid    <= 3'b000;
               end else if (any_valid) begin
                  child_len <= child_len + 1'b1;
                  valid     <= valid_next;
               end
            end
            default: ;
         endcase
      end
   end

   // Slot data mux for the child write port.
   always_comb begin
      bus.child_wr_data = slot0;
      unique case (sel)
         2'd1:    bus.child_wr_data = slot1;
         2'd2:    bus.child_wr_data = slot2;
         default: bus.child_wr_data = slot0;
      endcase
   end

   assign bus.par_rd_en     = rd_en;
   assign bus.par_rd_addr   = rd_ptr[ADDR_W-1:0];
   assign bus.eng_in_gene   = eng_in_q;
   assign bus.child_wr_en   = wr_en;
   assign bus.child_wr_addr = child_len[ADDR_W-1:0];
   assign busy              = (state != ST_IDLE) && (state != ST_DONE);
   assign done              = (state == ST_DONE);

endmodule

// File: tb/tb_eve_add_gene_sequencer.sv
// Bench for the add-gene sequencer: two instances (1024-gene and 4-gene child RAM) against a gene-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_eve_add_gene_sequencer;
   import eve_add_gene_sequencer_pkg::*;

   localparam logic [63:0] ONES = {64{1'b1}};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start_a, start_b;
   logic [10:0] plen_a;
   logic [2:0]  plen_b;
   logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
   logic [10:0] clen_a;
   logic [2:0]  clen_b;

   eve_add_gene_sequencer_if #(.ADDR_W(10)) bus_a ();
   eve_add_gene_sequencer_if #(.ADDR_W(2))  bus_b ();

   eve_add_gene_sequencer #(.ADDR_W(10)) dut_a (
      .clk(clk), .Reset(rst), .start(start_a), .parent_len(plen_a), .bus(bus_a),
      .busy(busy_a), .done(done_a), .overflow(ovf_a), .child_len(clen_a));

   eve_add_gene_sequencer #(.ADDR_W(2)) dut_b (
      .clk(clk), .Reset(rst), .start(start_b), .parent_len(plen_b), .bus(bus_b),
      .busy(busy_b), .done(done_b), .overflow(ovf_b), .child_len(clen_b));

   // Parent genome shared by both instances
   logic [63:0] pram [0:1023];
   int          eng_mode;   // 0: pass-through, 1: three valid outputs, 2: gene bits [2:0] pick valid slots

   // Engine stand-in: output slot k for an input gene; all-ones input means idle.
   function automatic logic [63:0] eng_slot(input logic [63:0] g, input int k, input int mode);
      logic v;
      if (g == ONES) return ONES;
      case (mode)
         0:       v = (k == 0);
         1:       v = 1'b1;
         default: v = g[k];
      endcase
      if (v) return g ^ (64'(k) << 8);
      return {8'hFF, g[55:0]};
   endfunction

   always @(posedge clk) begin
      if (bus_a.par_rd_en) bus_a.par_rd_data <= pram[bus_a.par_rd_addr];
      if (bus_b.par_rd_en) bus_b.par_rd_data <= pram[{8'd0, bus_b.par_rd_addr}];
      bus_a.eng_out1 <= eng_slot(bus_a.eng_in_gene, 0, eng_mode);
      bus_a.eng_out2 <= eng_slot(bus_a.eng_in_gene, 1, eng_mode);
      bus_a.eng_out3 <= eng_slot(bus_a.eng_in_gene, 2, eng_mode);
      bus_b.eng_out1 <= eng_slot(bus_b.eng_in_gene, 0, eng_mode);
      bus_b.eng_out2 <= eng_slot(bus_b.eng_in_gene, 1, eng_mode);
      bus_b.eng_out3 <= eng_slot(bus_b.eng_in_gene, 2, eng_mode);
   end

   // Observation mux so one checker serves either instance
   int          sel;
   logic        m_busy, m_done, m_ovf, m_rd, m_wr;
   logic [9:0]  m_waddr;
   logic [63:0] m_wdata;
   logic [10:0] m_len;
   always_comb begin
      if (sel == 0) begin
         m_busy = busy_a; m_done = done_a; m_ovf = ovf_a; m_rd = bus_a.par_rd_en;
         m_wr = bus_a.child_wr_en; m_waddr = bus_a.child_wr_addr; m_wdata = bus_a.child_wr_data;
         m_len = clen_a;
      end else begin
         m_busy = busy_b; m_done = done_b; m_ovf = ovf_b; m_rd = bus_b.par_rd_en;
         m_wr = bus_b.child_wr_en; m_waddr = {8'd0, bus_b.child_wr_addr}; m_wdata = bus_b.child_wr_data;
         m_len = {8'd0, clen_b};
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Gene-level model: expected child genome, overflow, reads and busy cycles
   logic [63:0] exp_q [$];
   int          exp_busy, exp_reads;
   bit          exp_ovf;

   task automatic build_expect(input int len, input int cap);
      logic [63:0] g, o;
      bit stop;
      exp_q.delete();
      exp_ovf = 0; exp_busy = 0; exp_reads = 0; stop = 0;
      for (int i = 0; i < len && !stop; i++) begin
         g = pram[i];
         exp_reads++;
         exp_busy += 2;                        // read + wait
         if (g[63:56] == 8'hFF) break;
         exp_busy += 2;                        // feed + capture
         for (int k = 0; k < 3 && !stop; k++) begin
            o = eng_slot(g, k, eng_mode);
            if (o[63:56] != 8'hFF) begin
               exp_busy++;
               if (exp_q.size() == cap) begin
                  exp_ovf = 1;
                  stop = 1;
               end else begin
                  exp_q.push_back(o);
               end
            end
         end
      end
   endtask

   // Start a pass on one instance and check every cycle until done
   task automatic run_pass(input int which, input int len, input int restart_at,
                           input string nm, output int busy_cnt);
      int cyc, nwr, rds;
      build_expect(len, (which == 0) ? 1024 : 4);
      sel = which;
      @(negedge clk);
      if (which == 0) begin start_a = 1'b1; plen_a = 11'(len); end
      else            begin start_b = 1'b1; plen_b = 3'(len); end
      @(negedge clk);
      busy_cnt = 0; nwr = 0; rds = 0; cyc = 0;
      while (!m_done && cyc < 4000) begin
         start_a = (which == 0) && (cyc == restart_at);
         start_b = (which == 1) && (cyc == restart_at);
         plen_a = 11'd7; plen_b = 3'd1;
         if (m_busy) busy_cnt++;
         if (m_rd) rds++;
         if (m_wr) begin
            if (nwr >= exp_q.size()) begin
               chk({nm, " extra write"}, 64'(nwr), 64'(exp_q.size()));
            end else begin
               chk({nm, " wr addr"}, 64'(m_waddr), 64'(nwr));
               chk({nm, " wr data"}, m_wdata, exp_q[nwr]);
            end
            nwr++;
         end
         @(negedge clk);
         cyc++;
      end
      start_a = 1'b0; start_b = 1'b0;
      chk({nm, " done seen"}, 64'(m_done), 64'd1);
      chk({nm, " busy cycles"}, 64'(busy_cnt), 64'(exp_busy));
      chk({nm, " writes"}, 64'(nwr), 64'(exp_q.size()));
      chk({nm, " reads"}, 64'(rds), 64'(exp_reads));
      chk({nm, " child_len"}, 64'(m_len), 64'(exp_q.size()));
      chk({nm, " overflow"}, 64'(m_ovf), 64'(exp_ovf));
      chk({nm, " busy at done"}, 64'(m_busy), 64'd0);
      @(negedge clk);
      chk({nm, " done one cycle"}, 64'(m_done), 64'd0);
      chk({nm, " child_len held"}, 64'(m_len), 64'(exp_q.size()));
   endtask

   function automatic logic [63:0] rand_gene();
      logic [63:0] g;
      g = {$urandom, $urandom};
      if (g[63:56] == 8'hFF) g[63:56] = 8'h01;
      if ($urandom_range(0, 9) == 0) g[63:56] = 8'hFF;
      return g;
   endfunction

   initial begin
      int bc, cyc;
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; plen_a = '0; plen_b = '0;
      sel = 0; eng_mode = 0;
      for (int i = 0; i < 1024; i++) pram[i] = 64'h0100_0000_0000_0000 | 64'(i);
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst busy", 64'(busy_a), 64'd0);
      chk("rst done", 64'(done_a), 64'd0);
      chk("rst overflow", 64'(ovf_a), 64'd0);
      chk("rst child_len", 64'(clen_a), 64'd0);
      chk("rst eng_in", bus_a.eng_in_gene, ONES);
      chk("rst rd_en", 64'(bus_a.par_rd_en), 64'd0);
      chk("rst wr_en", 64'(bus_a.child_wr_en), 64'd0);
      chk("rst rd_addr", 64'(bus_a.par_rd_addr), 64'd0);
      chk("rst wr_addr", 64'(bus_a.child_wr_addr), 64'd0);
      chk("rst b busy", 64'(busy_b), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Pass-through of three genes: 15 busy cycles
      pram[0] = 64'h1122_3344_5566_7788; pram[1] = 64'h2200_0000_0000_0001;
      pram[2] = 64'h3380_0000_0000_0002;
      eng_mode = 0;
      run_pass(0, 3, -1, "t1", bc);
      chk("t1 literal busy", 64'(bc), 64'd15);
      chk("t1 literal len", 64'(clen_a), 64'd3);

      // One connection gene yielding three outputs
      pram[0] = 64'h4580_0000_0000_00AA;
      eng_mode = 1;
      run_pass(0, 1, -1, "t2", bc);
      chk("t2 literal busy", 64'(bc), 64'd7);
      chk("t2 literal len", 64'(clen_a), 64'd3);

      // Terminator at gene 1 stops the pass
      pram[0] = 64'h0500_0000_0000_0001; pram[1] = 64'hFF00_0000_0000_0000;
      eng_mode = 0;
      run_pass(0, 5, -1, "t3", bc);
      chk("t3 literal len", 64'(clen_a), 64'd1);
      chk("t3 literal busy", 64'(bc), 64'd7);

      // Four-entry child RAM overflows
      pram[0] = 64'h0600_0000_0000_0010; pram[1] = 64'h0700_0000_0000_0020;
      eng_mode = 1;
      run_pass(1, 2, -1, "t4", bc);
      chk("t4 literal ovf", 64'(ovf_b), 64'd1);
      chk("t4 literal len", 64'(clen_b), 64'd4);

      // Reset during the drain of a three-output gene
      sel = 0;
      @(negedge clk);
      start_a = 1'b1; plen_a = 11'd2;
      @(negedge clk);
      start_a = 1'b0;
      cyc = 0;
      while (!bus_a.child_wr_en && cyc < 100) begin @(negedge clk); cyc++; end
      chk("t5 reached drain", 64'(bus_a.child_wr_en), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("t5 busy", 64'(busy_a), 64'd0);
      chk("t5 wr_en", 64'(bus_a.child_wr_en), 64'd0);
      chk("t5 eng_in", bus_a.eng_in_gene, ONES);
      chk("t5 child_len", 64'(clen_a), 64'd0);
      chk("t5 rd_addr", 64'(bus_a.par_rd_addr), 64'd0);
      rst = 1'b0;
      run_pass(0, 2, -1, "t5 clean", bc);

      // Empty parent and an ignored second start
      run_pass(0, 0, -1, "t6 empty", bc);
      chk("t6 literal busy", 64'(bc), 64'd0);
      eng_mode = 2;
      for (int i = 0; i < 8; i++) pram[i] = {8'(i + 1), 56'(i * 7 + 3)};
      run_pass(0, 8, 3, "t6 restart", bc);

      // Randomized passes on both instances
      for (int p = 0; p < 24; p++) begin
         for (int i = 0; i < 16; i++) pram[i] = rand_gene();
         eng_mode = $urandom_range(0, 2);
         if (p % 3 == 2) run_pass(1, $urandom_range(0, 4), -1, "rnd b", bc);
         else            run_pass(0, $urandom_range(0, 14), $urandom_range(0, 30), "rnd a", bc);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
